dual_issue_scheduler: RTL and testbench

// - Clocked in-order dual-issue scheduler between fetch and decode/execute.
// - Buffers fetched 16-bit instruction pairs in a small queue and tracks pending register writes in a per-register countdown scoreboard.
// - Each cycle it issues zero, one or two instructions and backpressures fetch.
// - Instr fields: opcode [15:12] (0 = nop), imm flag [11], dest [10:8], src1 [7:5], src2 [4:2] (src2 read only when [11]==0).

---
 rtl/dual_issue_scheduler.sv | 271 +++++++++++++++++++++++++++
 tb/tb_dual_issue_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler
// In-order dual-issue scheduler sitting between fetch and decode/execute.
// Fetched instruction pairs are buffered in a small circular queue. A
// per-register countdown scoreboard tracks pending writes. Each cycle up to
// two instructions are issued from the queue head into registered output
// slots, and fetch is backpressured through in_ready.
//
// Instruction fields: opcode [15:12] (0 = nop), imm [11], dest [10:8],
// src1 [7:5], src2 [4:2] (src2 only read when imm == 0).
//
// Optional macro FORWARD_EN: when defined, an issue loads the scoreboard
// with PIPE_LAT-1 to model an EX->EX bypass; when undefined it loads PIPE_LAT.

module dual_issue_scheduler #(
    parameter int PIPE_LAT = 2,   // issue-to-readable latency, >= 2
    parameter int QDEPTH   = 4,   // queue entries, power of 2, >= 2
    parameter int NREG     = 8    // architectural registers (3-bit index)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr1,
    input  logic [15:0] in_instr2,
    input  logic        flush,
    output logic [15:0] out_instr1,
    output logic [15:0] out_instr2,
    output logic [1:0]  issue_count,
    output logic        stall
);

    localparam int CNT_W = $clog2(PIPE_LAT + 1);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int OCC_W = $clog2(QDEPTH + 1);

`ifdef FORWARD_EN
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PIPE_LAT - 1);
`else
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PIPE_LAT);
`endif

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0]      q_mem [QDEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];

    logic [15:0]      out1_q;
    logic [15:0]      out2_q;
    logic [1:0]       count_q;

    state_t           state_q;
    logic             stall_q;

    // ------------------------------------------------------------------
    // Push side
    // ------------------------------------------------------------------
    logic [OCC_W-1:0] free_slots;
    logic             accept;
    logic             in1_live;
    logic             in2_live;
    logic             wr0_en;
    logic             wr1_en;
    logic [15:0]      wr0_data;
    logic [15:0]      wr1_data;
    logic [1:0]       n_push;

    assign free_slots = OCC_W'(QDEPTH) - occ_q;
    assign in_ready   = (free_slots >= OCC_W'(2)) && !flush;
    assign accept     = in_valid && in_ready;
    assign in1_live   = (in_instr1[15:12] != 4'h0);
    assign in2_live   = (in_instr2[15:12] != 4'h0);

    // Compact the accepted pair: nops are dropped, survivors keep their order.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        wr0_data = in_instr1;
        wr1_data = in_instr2;
        n_push   = 2'd0;
        if (accept) begin
            if (in1_live && in2_live) begin
                wr0_en = 1'b1;
                wr1_en = 1'b1;
                n_push = 2'd2;
            end else if (in1_live) begin
                wr0_en = 1'b1;
                n_push = 2'd1;
            end else if (in2_live) begin
                wr0_en   = 1'b1;
                wr0_data = in_instr2;
                n_push   = 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue side: head and head+1 checked against the scoreboard
    // ------------------------------------------------------------------
    logic [15:0] head_instr;
    logic [15:0] next_instr;
    logic        head_vld;
    logic        next_vld;
    logic        haz1;
    logic        haz2;
    logic        raw2;
    logic        waw2;
    logic        issue1;
    logic        issue2;
    logic [1:0]  n_pop;

    assign head_instr = q_mem[head_q];
    assign next_instr = q_mem[head_q + PTR_W'(1)];
    assign head_vld   = (occ_q != '0);
    assign next_vld   = (occ_q > OCC_W'(1));

    // A source is blocked while its producer still has more than one cycle to go.
    assign haz1 = (cnt_q[head_instr[7:5]] > CNT_W'(1)) ||
                  (!head_instr[11] && (cnt_q[head_instr[4:2]] > CNT_W'(1)));
    assign haz2 = (cnt_q[next_instr[7:5]] > CNT_W'(1)) ||
                  (!next_instr[11] && (cnt_q[next_instr[4:2]] > CNT_W'(1)));

    // The younger slot may not read or overwrite what the older slot writes.
    assign raw2 = (next_instr[7:5] == head_instr[10:8]) ||
                  (!next_instr[11] && (next_instr[4:2] == head_instr[10:8]));
    assign waw2 = (next_instr[10:8] == head_instr[10:8]);

    assign issue1 = head_vld && !haz1 && !flush;
    assign issue2 = issue1 && next_vld && !haz2 && !raw2 && !waw2;
    assign n_pop  = {1'b0, issue1} + {1'b0, issue2};

    assign occ_d = occ_q - OCC_W'(n_pop) + OCC_W'(n_push);

    // Scoreboard next state: an issue load beats the countdown on the same edge.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if ((issue1 && (head_instr[10:8] == 3'(r))) ||
                (issue2 && (next_instr[10:8] == 3'(r)))) begin
                cnt_d[r] = LOAD_VAL;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Queue storage writes; validity is tracked by the pointers and occupancy.
    // NOTE: the storage array has no reset -- occupancy already marks every entry invalid after reset or flush.
    always_ff @(posedge clk) begin
        if (wr0_en) begin
            q_mem[tail_q] <= wr0_data;
        end
        if (wr1_en) begin
            q_mem[tail_q + PTR_W'(1)] <= wr1_data;
        end
    end

    // Queue pointers and occupancy; flush empties the queue and ignores any push.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else if (flush) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_q + PTR_W'(n_pop);
            tail_q <= tail_q + PTR_W'(n_push);
            occ_q  <= occ_d;
        end
    end

    // Scoreboard counters; flush discards all pending writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else if (flush) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Registered issue slots; an unissued slot carries a nop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out1_q  <= 16'h0000;
            out2_q  <= 16'h0000;
            count_q <= 2'd0;
        end else if (flush) begin
            out1_q  <= 16'h0000;
            out2_q  <= 16'h0000;
            count_q <= 2'd0;
        end else begin
            out1_q  <= issue1 ? head_instr : 16'h0000;
            out2_q  <= issue2 ? next_instr : 16'h0000;
            count_q <= n_pop;
        end
    end

    // Control FSM with registered stall: EMPTY -> RUN on push, RUN <-> HOLD on head hazard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            stall_q <= 1'b0;
        end else if (flush) begin
            state_q <= ST_EMPTY;
            stall_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (n_push != 2'd0) begin
                        state_q <= ST_RUN;
                        stall_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (occ_d == '0) begin
                        state_q <= ST_EMPTY;
                        stall_q <= 1'b0;
                    end else if (head_vld && haz1) begin
                        state_q <= ST_HOLD;
                        stall_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (issue1) begin
                        state_q <= ST_RUN;
                        stall_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_instr1  = out1_q;
    assign out_instr2  = out2_q;
    assign issue_count = count_q;
    assign stall       = stall_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb_dual_issue_scheduler
// Directed bench for dual_issue_scheduler in its default build (FORWARD_EN
// undefined, PIPE_LAT=2, QDEPTH=4). Every accepted non-nop instruction is
// pushed to an expected-issue queue when it is offered; every non-nop that
// appears on an output slot is popped and compared, so issue order is
// checked continuously. Cycle-specific expectations (issue_count, stall,
// in_ready) are checked at each directed step.

module tb_dual_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr1;
    logic [15:0] in_instr2;
    logic        flush;
    logic [15:0] out_instr1;
    logic [15:0] out_instr2;
    logic [1:0]  issue_count;
    logic        stall;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [15:0] exp_q [$];

    dual_issue_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr1   (in_instr1),
        .in_instr2   (in_instr2),
        .flush       (flush),
        .out_instr1  (out_instr1),
        .out_instr2  (out_instr2),
        .issue_count (issue_count),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Compare one issued slot against the oldest outstanding expected instruction.
    task automatic scan(input logic [15:0] obs, input string tag);
        logic [15:0] e;
        if (obs !== 16'h0000) begin
            if (exp_q.size() == 0) e = 16'h0000;
            else                   e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    // Advance one clock and scoreboard whatever was issued at that edge.
    task automatic step();
        @(posedge clk);
        #1;
        scan(out_instr1, "issue_slot1");
        scan(out_instr2, "issue_slot2");
    endtask

    // Present a pair that must be accepted at the next edge.
    task automatic offer(input logic [15:0] i1, input logic [15:0] i2);
        in_valid  = 1'b1;
        in_instr1 = i1;
        in_instr2 = i2;
        flush     = 1'b0;
        #1;
        check("in_ready_offer", 16'(in_ready), 16'h0001);
        if (i1[15:12] != 4'h0) exp_q.push_back(i1);
        if (i2[15:12] != 4'h0) exp_q.push_back(i2);
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_instr1 = 16'h0000;
        in_instr2 = 16'h0000;
        flush     = 1'b0;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr1 = 16'h0000;
        in_instr2 = 16'h0000;
        flush     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out1",  out_instr1, 16'h0000);
        check("rst_out2",  out_instr2, 16'h0000);
        check("rst_count", 16'(issue_count), 16'h0000);
        check("rst_stall", 16'(stall), 16'h0000);
        check("rst_ready", 16'(in_ready), 16'h0001);
        @(negedge clk);
        rst = 1'b0;

        // Independent pair dual-issues one edge after acceptance
        offer(16'h114C, 16'h15DC);
        step();
        idle();
        check("t1_latency_count", 16'(issue_count), 16'h0000);
        step();
        check("t1_count", 16'(issue_count), 16'h0002);
        check("t1_stall", 16'(stall), 16'h0000);
        step();
        check("t1_idle_count", 16'(issue_count), 16'h0000);
        check("t1_idle_stall", 16'(stall), 16'h0000);

        // RAW pair: producer alone, consumer held then issued two edges later
        offer(16'h114C, 16'h1428);
        step();
        idle();
        step();
        check("t2_prod_count", 16'(issue_count), 16'h0001);
        check("t2_prod_out2",  out_instr2, 16'h0000);
        check("t2_prod_stall", 16'(stall), 16'h0000);
        step();
        check("t2_hold_count", 16'(issue_count), 16'h0000);
        check("t2_hold_stall", 16'(stall), 16'h0001);
        step();
        check("t2_cons_count", 16'(issue_count), 16'h0001);
        check("t2_cons_stall", 16'(stall), 16'h0000);
        step();
        check("t2_done_count", 16'(issue_count), 16'h0000);

        // Immediate consumer: src2 field aliases the older dest but is ignored
        offer(16'h104C, 16'h2A20);
        step();
        idle();
        step();
        check("t3_count", 16'(issue_count), 16'h0002);
        step();
        step();

        // Fill queue behind a blocked head, then release
        offer(16'h114C, 16'h1428);
        step();
        offer(16'h361C, 16'h4F60);
        step();
        idle();
        check("t4_count_prod", 16'(issue_count), 16'h0001);
        check("t4_full_ready", 16'(in_ready), 16'h0000);
        step();
        check("t4_hold_stall", 16'(stall), 16'h0001);
        check("t4_hold_ready", 16'(in_ready), 16'h0000);
        step();
        check("t4_release_count", 16'(issue_count), 16'h0002);
        check("t4_release_ready", 16'(in_ready), 16'h0001);
        check("t4_release_stall", 16'(stall), 16'h0000);
        step();
        check("t4_tail_count", 16'(issue_count), 16'h0001);
        step();
        check("t4_drained_count", 16'(issue_count), 16'h0000);

        // Flush in HOLD with a same-cycle push that must be discarded
        offer(16'h114C, 16'h1428);
        step();
        idle();
        step();
        step();
        check("t5_hold_stall", 16'(stall), 16'h0001);
        in_valid  = 1'b1;
        in_instr1 = 16'h361C;
        in_instr2 = 16'h4F60;
        flush     = 1'b1;
        #1;
        check("t5_flush_ready", 16'(in_ready), 16'h0000);
        exp_q.delete();
        step();
        idle();
        check("t5_out1",  out_instr1, 16'h0000);
        check("t5_out2",  out_instr2, 16'h0000);
        check("t5_count", 16'(issue_count), 16'h0000);
        check("t5_stall", 16'(stall), 16'h0000);
        check("t5_ready", 16'(in_ready), 16'h0001);
        step();
        step();
        check("t5_discard_count", 16'(issue_count), 16'h0000);

        // Asynchronous reset in the middle of HOLD
        offer(16'h114C, 16'h1428);
        step();
        idle();
        step();
        step();
        check("t6_hold_stall", 16'(stall), 16'h0001);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_out1",  out_instr1, 16'h0000);
        check("t6_rst_out2",  out_instr2, 16'h0000);
        check("t6_rst_stall", 16'(stall), 16'h0000);
        check("t6_rst_count", 16'(issue_count), 16'h0000);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        offer(16'h1428, 16'h0000);
        step();
        idle();
        step();
        check("t6_after_count", 16'(issue_count), 16'h0001);
        check("t6_after_out2",  out_instr2, 16'h0000);
        check("t6_after_stall", 16'(stall), 16'h0000);
        step();

        check("all_issued", 16'(exp_q.size()), 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
